// File: rtl/ball_tx_packetizer.sv
// Ball hand-off framer: snapshots ball state, builds a 6-byte checksummed frame,
// streams it to the board-to-board I2C master and retries NACKed frames.
module ball_tx_packetizer #(
    parameter logic [7:0]  HEADER    = 8'hA5,
    parameter int unsigned MAX_RETRY = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ball_send_trigger,
    input  logic [9:0] ball_y,
    input  logic [7:0] ball_vy,
    input  logic [1:0] gravity_counter,
    input  logic [7:0] safe_speed,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       tx_last,
    input  logic       tx_nack,
    output logic       is_transfer,
    output logic       frame_done,
    output logic       frame_err,
    output logic [7:0] err_cnt
);

    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [2:0] LAST_IDX = 3'd5;

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        RETRY,
        DONE,
        ABORT
    } state_t;

    state_t          state;
    logic            pending;
    logic [RW-1:0]   retry_cnt;
    logic [2:0]      byte_idx;

    logic [9:0]      snap_y;
    logic [7:0]      snap_vy;
    logic [1:0]      snap_grav;
    logic [7:0]      snap_speed;

    logic [7:0]      b1;
    logic [7:0]      b2;
    logic [7:0]      b3;
    logic [7:0]      b4;
    logic [7:0]      b5;
    logic [2:0]      next_idx;
    logic [7:0]      next_byte;
    logic            can_retry;

    // Every frame byte derives from the snapshot, never the live inputs.
    assign b1 = {4'b0000, snap_grav, snap_y[9:8]};
    assign b2 = snap_y[7:0];
    assign b3 = snap_vy;
    assign b4 = snap_speed;
    assign b5 = HEADER ^ b1 ^ b2 ^ b3 ^ b4;

    assign can_retry = (retry_cnt < RW'(MAX_RETRY));

    always_comb begin
        next_idx  = byte_idx + 3'd1;
        next_byte = HEADER;
        case (next_idx)
            3'd1:    next_byte = b1;
            3'd2:    next_byte = b2;
            3'd3:    next_byte = b3;
            3'd4:    next_byte = b4;
            3'd5:    next_byte = b5;
            default: next_byte = HEADER;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            pending     <= 1'b0;
            retry_cnt   <= '0;
            byte_idx    <= 3'd0;
            snap_y      <= 10'd0;
            snap_vy     <= 8'd0;
            snap_grav   <= 2'd0;
            snap_speed  <= 8'd0;
            tx_data     <= 8'd0;
            tx_valid    <= 1'b0;
            tx_last     <= 1'b0;
            is_transfer <= 1'b0;
            frame_done  <= 1'b0;
            frame_err   <= 1'b0;
            err_cnt     <= 8'd0;
        end else begin
            frame_done <= 1'b0;
            frame_err  <= 1'b0;

            // Triggers while busy collapse into one deferred frame.
            if (ball_send_trigger && state != IDLE) begin
                pending <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (ball_send_trigger || pending) begin
                        snap_y      <= ball_y;
                        snap_vy     <= ball_vy;
                        snap_grav   <= gravity_counter;
                        snap_speed  <= safe_speed;
                        byte_idx    <= 3'd0;
                        retry_cnt   <= '0;
                        pending     <= 1'b0;
                        tx_valid    <= 1'b1;
                        tx_data     <= HEADER;
                        tx_last     <= 1'b0;
                        is_transfer <= 1'b1;
                        state       <= SEND;
                    end
                end

                SEND: begin
                    if (tx_nack) begin
                        tx_valid <= 1'b0;
                        tx_last  <= 1'b0;
                        tx_data  <= 8'd0;
                        state    <= RETRY;
                    end else if (tx_ready) begin
                        if (byte_idx == LAST_IDX) begin
                            tx_valid    <= 1'b0;
                            tx_last     <= 1'b0;
                            tx_data     <= 8'd0;
                            frame_done  <= 1'b1;
                            is_transfer <= 1'b0;
                            state       <= DONE;
                        end else begin
                            byte_idx <= next_idx;
                            tx_data  <= next_byte;
                            tx_last  <= (next_idx == LAST_IDX);
                        end
                    end
                end

                RETRY: begin
                    if (can_retry) begin
                        retry_cnt <= retry_cnt + RW'(1);
                        byte_idx  <= 3'd0;
                        tx_valid  <= 1'b1;
                        tx_data   <= HEADER;
                        tx_last   <= 1'b0;
                        state     <= SEND;
                    end else begin
                        frame_err   <= 1'b1;
                        is_transfer <= 1'b0;
                        if (err_cnt != 8'hFF) begin
                            err_cnt <= err_cnt + 8'd1;
                        end
                        state <= ABORT;
                    end
                end

                DONE: begin
                    state <= IDLE;
                end

                ABORT: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ball_tx_packetizer.sv
// Directed bench for ball_tx_packetizer with a byte scoreboard fed at
// trigger time and drained on every accepted handshake.
module tb_ball_tx_packetizer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       ball_send_trigger = 1'b0;
    logic [9:0] ball_y = 10'h2C3;
    logic [7:0] ball_vy = 8'hF0;
    logic [1:0] gravity_counter = 2'b01;
    logic [7:0] safe_speed = 8'h12;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready = 1'b1;
    logic       tx_last;
    logic       tx_nack = 1'b0;
    logic       is_transfer;
    logic       frame_done;
    logic       frame_err;
    logic [7:0] err_cnt;

    logic [8:0] exp_q[$];
    int vectors = 0;
    int miss = 0;
    int done_cnt = 0;
    int err_pulses = 0;
    int send_cyc = 0;
    int xfer_cyc = 0;

    ball_tx_packetizer dut (
        .clk(clk),
        .reset(reset),
        .ball_send_trigger(ball_send_trigger),
        .ball_y(ball_y),
        .ball_vy(ball_vy),
        .gravity_counter(gravity_counter),
        .safe_speed(safe_speed),
        .tx_data(tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .tx_last(tx_last),
        .tx_nack(tx_nack),
        .is_transfer(is_transfer),
        .frame_done(frame_done),
        .frame_err(frame_err),
        .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    function automatic void push_frame(input logic [9:0] fy, input logic [7:0] fvy,
                                       input logic [1:0] fg, input logic [7:0] fs);
        logic [7:0] b[6];
        b[0] = 8'hA5;
        b[1] = {4'b0000, fg, fy[9:8]};
        b[2] = fy[7:0];
        b[3] = fvy;
        b[4] = fs;
        b[5] = b[0] ^ b[1] ^ b[2] ^ b[3] ^ b[4];
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back({(i == 5) ? 1'b1 : 1'b0, b[i]});
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp)
        else begin
            miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Score the handshake present in the current cycle, then advance one clock.
    task automatic step();
        logic [8:0] e;
        if (reset && tx_valid && tx_ready && !tx_nack) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miss++;
                $error("FAIL unexpected_byte: observed %0h expected none", tx_data);
            end else begin
                e = exp_q.pop_front();
                chk("byte", {23'd0, tx_last, tx_data}, {23'd0, e});
            end
        end
        if (tx_valid) send_cyc++;
        if (is_transfer) xfer_cyc++;
        if (frame_done) done_cnt++;
        if (frame_err) err_pulses++;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_byte(input logic [7:0] v, input string tag);
        int n = 0;
        while (!(tx_valid && tx_data == v) && n < 30) begin
            step();
            n++;
        end
        chk(tag, {24'd0, tx_data}, {24'd0, v});
    endtask

    task automatic run_done(input string tag);
        int n = 0;
        while (!frame_done && n < 60) begin
            step();
            n++;
        end
        chk(tag, {31'd0, frame_done}, 32'd1);
        step();
    endtask

    task automatic trigger();
        ball_send_trigger = 1'b1;
        step();
        ball_send_trigger = 1'b0;
    endtask

    task automatic set_base();
        ball_y = 10'h2C3;
        ball_vy = 8'hF0;
        gravity_counter = 2'b01;
        safe_speed = 8'h12;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int d0;
        #1;
        step();
        step();
        chk("rst_valid", {31'd0, tx_valid}, 32'd0);
        chk("rst_data", {24'd0, tx_data}, 32'd0);
        chk("rst_xfer", {31'd0, is_transfer}, 32'd0);
        chk("rst_errcnt", {24'd0, err_cnt}, 32'd0);
        reset = 1'b1;
        step();

        // Basic frame, ready tied high
        set_base();
        push_frame(ball_y, ball_vy, gravity_counter, safe_speed);
        send_cyc = 0;
        xfer_cyc = 0;
        trigger();
        chk("lat_valid", {31'd0, tx_valid}, 32'd1);
        chk("lat_b0", {24'd0, tx_data}, 32'hA5);
        run_done("basic_done");
        chk("basic_send_cyc", send_cyc, 6);
        chk("basic_xfer_cyc", xfer_cyc, 6);
        chk("basic_done_cnt", done_cnt, 1);
        chk("basic_q_empty", exp_q.size(), 0);

        // Backpressure on B2 with inputs moving mid-frame
        push_frame(ball_y, ball_vy, gravity_counter, safe_speed);
        send_cyc = 0;
        trigger();
        step();
        ball_y = 10'h3FF;
        ball_vy = 8'h11;
        gravity_counter = 2'b10;
        safe_speed = 8'h77;
        wait_byte(8'hC3, "bp_reach_b2");
        tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("bp_hold", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, 8'hC3});
            step();
        end
        tx_ready = 1'b1;
        run_done("bp_done");
        chk("bp_send_cyc", send_cyc, 9);
        chk("bp_q_empty", exp_q.size(), 0);
        set_base();

        // One NACK on B3 (ready also high), retry succeeds
        d0 = done_cnt;
        push_frame(ball_y, ball_vy, gravity_counter, safe_speed);
        trigger();
        wait_byte(8'hF0, "nack_reach_b3");
        tx_nack = 1'b1;
        step();
        tx_nack = 1'b0;
        exp_q.delete();
        push_frame(ball_y, ball_vy, gravity_counter, safe_speed);
        chk("nack_valid_drop", {31'd0, tx_valid}, 32'd0);
        step();
        chk("retry_b0", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, 8'hA5});
        run_done("retry_done");
        chk("retry_done_cnt", done_cnt - d0, 1);
        chk("retry_no_err", err_pulses, 0);
        chk("retry_errcnt", {24'd0, err_cnt}, 32'd0);
        chk("retry_q_empty", exp_q.size(), 0);

        // NACK on every attempt: frame dropped after MAX_RETRY
        d0 = done_cnt;
        push_frame(ball_y, ball_vy, gravity_counter, safe_speed);
        trigger();
        for (int i = 0; i < 3; i++) begin
            chk("abort_b0", {24'd0, tx_data}, 32'hA5);
            step();
            tx_nack = 1'b1;
            step();
            tx_nack = 1'b0;
            exp_q.delete();
            if (i < 2) begin
                push_frame(ball_y, ball_vy, gravity_counter, safe_speed);
                chk("abort_retry_gap", {31'd0, tx_valid}, 32'd0);
                step();
            end
        end
        step();
        chk("abort_err_pulse", {31'd0, frame_err}, 32'd1);
        chk("abort_errcnt", {24'd0, err_cnt}, 32'd1);
        step();
        chk("abort_valid", {31'd0, tx_valid}, 32'd0);
        chk("abort_xfer", {31'd0, is_transfer}, 32'd0);
        chk("abort_err_once", err_pulses, 1);
        chk("abort_no_done", done_cnt - d0, 0);

        // Two triggers while busy merge into one fresh frame
        d0 = done_cnt;
        push_frame(ball_y, ball_vy, gravity_counter, safe_speed);
        trigger();
        trigger();
        step();
        trigger();
        ball_y = 10'h001;
        gravity_counter = 2'b00;
        push_frame(ball_y, ball_vy, gravity_counter, safe_speed);
        run_done("pend_first_done");
        run_done("pend_second_done");
        chk("pend_done_cnt", done_cnt - d0, 2);
        chk("pend_q_empty", exp_q.size(), 0);
        repeat (5) step();
        chk("pend_no_third", {31'd0, tx_valid}, 32'd0);
        set_base();

        // Reset mid-frame drops the frame and the pending trigger
        push_frame(ball_y, ball_vy, gravity_counter, safe_speed);
        trigger();
        step();
        trigger();
        wait_byte(8'hC3, "rst_reach_b2");
        d0 = done_cnt;
        reset = 1'b0;
        step();
        reset = 1'b1;
        exp_q.delete();
        chk("mid_rst_valid", {31'd0, tx_valid}, 32'd0);
        chk("mid_rst_last", {31'd0, tx_last}, 32'd0);
        chk("mid_rst_data", {24'd0, tx_data}, 32'd0);
        chk("mid_rst_xfer", {31'd0, is_transfer}, 32'd0);
        chk("mid_rst_errcnt", {24'd0, err_cnt}, 32'd0);
        repeat (4) step();
        chk("mid_rst_no_pend", {31'd0, tx_valid}, 32'd0);
        chk("mid_rst_no_done", done_cnt - d0, 0);
        push_frame(ball_y, ball_vy, gravity_counter, safe_speed);
        trigger();
        chk("post_rst_b0", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, 8'hA5});
        run_done("post_rst_done");
        chk("post_rst_q_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
        $finish;
    end

endmodule
